// File: rtl/delay_measure.sv
// delay_measure
//   Measures the number of clock edges between a rising edge on trigger_in
//   and the first edge at which the active-low delay_in_n is sampled low,
//   scales the count by a right shift of 0..3 and reports the result.
//
// Ports
//   clk               sole clock, rising-edge active
//   rst               asynchronous active-high reset
//   trigger_in        starts a measurement on its rising edge; dropping it
//                     mid-measurement cancels the measurement
//   delay_in_n        active-low delayed signal under measurement
//   mode_a, mode_b    scale shift {mode_b,mode_a}, captured at measurement start
//   weighted_bits_out last scaled result (saturates at all-ones)
//   meas_valid        one-cycle pulse when weighted_bits_out updates
//   overflow          last result saturated; updates with meas_valid
//   abort             one-cycle pulse when a measurement is cancelled
//   busy              high while a measurement is in progress
module delay_measure #(
  parameter int WEIGHT_BIT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trigger_in,
  input  logic                        delay_in_n,
  input  logic                        mode_a,
  input  logic                        mode_b,
  output logic [WEIGHT_BIT_WIDTH-1:0] weighted_bits_out,
  output logic                        meas_valid,
  output logic                        overflow,
  output logic                        abort,
  output logic                        busy
);

  localparam int CW = WEIGHT_BIT_WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        trig_q;
  logic                        rise;
  logic [CW-1:0]               count_q, count_d;
  logic [CW-1:0]               count_inc;
  logic [1:0]                  shift_q, shift_d;
  logic [1:0]                  eff_shift;
  logic [CW-1:0]               raw;
  logic [CW-1:0]               shifted;
  logic                        finish;
  logic [WEIGHT_BIT_WIDTH-1:0] weighted_q, weighted_d;
  logic                        overflow_q, overflow_d;
  logic                        meas_valid_q, meas_valid_d;
  logic                        abort_q, abort_d;

  assign rise = trigger_in & ~trig_q;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign count_inc = (&count_q) ? count_q : count_q + CW'(1);

  // At the start edge the shift comes straight from the mode pins; afterwards
  // the captured copy is used so mode changes mid-measurement have no effect.
  assign eff_shift = (state_q == IDLE) ? {mode_b, mode_a} : shift_q;

  assign shifted = raw >> eff_shift;

  // Next-state and result logic. The counter holds k-1 at the edge E0+k, so
  // the completing edge reports count_q+1; completion at the start edge
  // itself reports zero. Completion is tested before abort so that a
  // simultaneous trigger drop still yields a result.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    weighted_d   = weighted_q;
    overflow_d   = overflow_q;
    meas_valid_d = 1'b0;
    abort_d      = 1'b0;
    finish       = 1'b0;
    raw          = '0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          count_d = '0;
          shift_d = {mode_b, mode_a};
          if (!delay_in_n) begin
            finish = 1'b1;
            raw    = '0;
          end else begin
            state_d = MEASURE;
          end
        end
      end
      MEASURE: begin
        if (!delay_in_n) begin
          finish = 1'b1;
          raw    = count_inc;
        end else if (!trigger_in) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The result is loaded on the completing edge so that it is visible in
    // the DONE cycle together with the meas_valid pulse.
    if (finish) begin
      state_d      = DONE;
      meas_valid_d = 1'b1;
      if (|shifted[CW-1:WEIGHT_BIT_WIDTH]) begin
        weighted_d = '1;
        overflow_d = 1'b1;
      end else begin
        weighted_d = shifted[WEIGHT_BIT_WIDTH-1:0];
        overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      trig_q       <= 1'b0;
      count_q      <= '0;
      shift_q      <= 2'd0;
      weighted_q   <= '0;
      overflow_q   <= 1'b0;
      meas_valid_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_q       <= trigger_in;
      count_q      <= count_d;
      shift_q      <= shift_d;
      weighted_q   <= weighted_d;
      overflow_q   <= overflow_d;
      meas_valid_q <= meas_valid_d;
      abort_q      <= abort_d;
    end
  end

  assign weighted_bits_out = weighted_q;
  assign overflow          = overflow_q;
  assign meas_valid        = meas_valid_q;
  assign abort             = abort_q;
  assign busy              = (state_q == MEASURE);

endmodule

// File: tb/tb_delay_measure.sv
// Self-checking testbench for delay_measure (WEIGHT_BIT_WIDTH = 8).
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
module tb_delay_measure;

  localparam int W    = 8;
  localparam int MAXC = (1 << (W + 3)) - 1;
  localparam int MAXR = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         trigger_in;
  logic         delay_in_n;
  logic         mode_a;
  logic         mode_b;
  logic [W-1:0] weighted_bits_out;
  logic         meas_valid;
  logic         overflow;
  logic         abort;
  logic         busy;

  int n_checks;
  int n_fail;

  delay_measure #(.WEIGHT_BIT_WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .trigger_in       (trigger_in),
    .delay_in_n       (delay_in_n),
    .mode_a           (mode_a),
    .mode_b           (mode_b),
    .weighted_bits_out(weighted_bits_out),
    .meas_valid       (meas_valid),
    .overflow         (overflow),
    .abort            (abort),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the delay k in edges, clipped at the counter ceiling, shifted
  // right by the mode, then clipped to the output range.
  function automatic void model(input int k, input int s,
                                output logic [W-1:0] r, output logic o);
    int raw_v;
    int v;
    raw_v = (k > MAXC) ? MAXC : k;
    v = raw_v >> s;
    if (v > MAXR) begin
      r = '1;
      o = 1'b1;
    end else begin
      r = W'(v);
      o = 1'b0;
    end
  endfunction

  // Runs one measurement whose delay_in_n goes low at edge E0+k. Mode pins
  // are scrambled during the measurement. Returns what was seen.
  task automatic do_measure(input int k, input int mode, input bit drop_at_end,
                            input bit hold_after,
                            output bit valid_done, output bit extra_valid,
                            output logic [W-1:0] res, output logic ovf,
                            output int busy_err);
    busy_err = 0;
    @(negedge clk);
    trigger_in = 1'b1;
    {mode_b, mode_a} = 2'(mode);
    delay_in_n = (k == 0) ? 1'b0 : 1'b1;
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      if (busy !== 1'b1 || meas_valid !== 1'b0) busy_err++;
      {mode_b, mode_a} = 2'($urandom);
      if (j == k) begin
        delay_in_n = 1'b0;
        if (drop_at_end) trigger_in = 1'b0;
      end
    end
    @(negedge clk);
    valid_done = (meas_valid === 1'b1);
    res = weighted_bits_out;
    ovf = overflow;
    if (busy !== 1'b0) busy_err++;
    delay_in_n = 1'b1;
    trigger_in = hold_after;
    @(negedge clk);
    extra_valid = (meas_valid !== 1'b0);
  endtask

  // Runs a measurement and compares it against the reference model.
  task automatic checked_measure(input string name, input int k, input int mode,
                                 input bit drop_at_end);
    bit           vd, ev;
    logic [W-1:0] res, exp_r;
    logic         ovf, exp_o;
    int           be;
    do_measure(k, mode, drop_at_end, 1'b0, vd, ev, res, ovf, be);
    model(k, mode, exp_r, exp_o);
    n_checks++;
    if (!vd || ev || be != 0 || res !== exp_r || ovf !== exp_o) begin
      n_fail++;
      $display("[TB] FAIL %s k=%0d mode=%0d: got res=%0d ovf=%b valid=%b extra=%b busy_err=%0d, want res=%0d ovf=%b valid=1 extra=0 busy_err=0",
               name, k, mode, res, ovf, vd, ev, be, exp_r, exp_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    trigger_in = 1'b0;
    delay_in_n = 1'b1;
    mode_a = 1'b0;
    mode_b = 1'b0;
    #1;
    n_checks++;
    if ({weighted_bits_out, meas_valid, overflow, abort, busy} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got out=%0d mv=%b ov=%b ab=%b busy=%b, want all 0",
               weighted_bits_out, meas_valid, overflow, abort, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    checked_measure("basic_mode0_k10", 10, 0, 1'b0);
    checked_measure("mode3_k83", 83, 3, 1'b0);
    checked_measure("overflow_mode0_k300", 300, 0, 1'b0);
    checked_measure("mode2_k300", 300, 2, 1'b0);
    checked_measure("k1_edge", 1, 0, 1'b0);
    checked_measure("max_no_ovf_k255", 255, 0, 1'b0);
    checked_measure("min_ovf_k256", 256, 0, 1'b0);
  endtask

  task automatic test_saturation;
    checked_measure("counter_saturates_k2100", 2100, 3, 1'b0);
  endtask

  task automatic test_abort;
    checked_measure("pre_abort_k10", 10, 0, 1'b0);
    @(negedge clk);
    trigger_in = 1'b1;
    delay_in_n = 1'b1;
    {mode_b, mode_a} = 2'd0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 5) trigger_in = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (abort !== 1'b1 || meas_valid !== 1'b0 || busy !== 1'b0 ||
        weighted_bits_out !== 8'd10 || overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_pulse: got ab=%b mv=%b busy=%b out=%0d ov=%b, want ab=1 mv=0 busy=0 out=10 ov=0",
               abort, meas_valid, busy, weighted_bits_out, overflow);
    end
    @(negedge clk);
    n_checks++;
    if (abort !== 1'b0 || meas_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_one_cycle: got ab=%b mv=%b, want ab=0 mv=0", abort, meas_valid);
    end
  endtask

  task automatic test_priority;
    checked_measure("complete_beats_abort_k6", 6, 1, 1'b1);
  endtask

  task automatic test_immediate_hold;
    bit           vd, ev;
    logic [W-1:0] res;
    logic         ovf;
    int           be;
    int           stray;
    do_measure(0, 0, 1'b0, 1'b1, vd, ev, res, ovf, be);
    n_checks++;
    if (!vd || ev || be != 0 || res !== 8'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL immediate_k0: got res=%0d ovf=%b valid=%b extra=%b busy_err=%0d, want res=0 ovf=0 valid=1 extra=0 busy_err=0",
               res, ovf, vd, ev, be);
    end
    stray = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (meas_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("[TB] FAIL held_trigger_no_restart: got %0d active cycles, want 0", stray);
    end
    trigger_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int pulses;
    checked_measure("pre_reset_k10", 10, 0, 1'b0);
    @(negedge clk);
    trigger_in = 1'b1;
    delay_in_n = 1'b1;
    {mode_b, mode_a} = 2'd0;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({weighted_bits_out, meas_valid, overflow, abort, busy} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_mid: got out=%0d mv=%b ov=%b ab=%b busy=%b, want all 0",
               weighted_bits_out, meas_valid, overflow, abort, busy);
    end
    pulses = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (meas_valid !== 1'b0 || abort !== 1'b0) pulses++;
    end
    trigger_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    if (meas_valid !== 1'b0 || abort !== 1'b0) pulses++;
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_pulses: got %0d pulse cycles, want 0", pulses);
    end
    checked_measure("post_reset_k20", 20, 0, 1'b0);
  endtask

  task automatic test_trigger_high_at_reset;
    @(negedge clk);
    rst = 1'b1;
    trigger_in = 1'b1;
    delay_in_n = 1'b1;
    {mode_b, mode_a} = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j == 7) delay_in_n = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (meas_valid !== 1'b1 || weighted_bits_out !== 8'd7 || overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rise_after_reset: got mv=%b out=%0d ov=%b, want mv=1 out=7 ov=0",
               meas_valid, weighted_bits_out, overflow);
    end
    trigger_in = 1'b0;
    delay_in_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      checked_measure("random", int'($urandom_range(0, 400)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back;
    checked_measure("b2b_a", 3, 0, 1'b0);
    checked_measure("b2b_b", 40, 1, 1'b0);
    checked_measure("b2b_c", 0, 2, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_abort();
    test_priority();
    test_immediate_hold();
    test_reset_mid();
    test_trigger_high_at_reset();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_measure.md
DELAY_MEASURE -- requirements
Module: delay_measure

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WEIGHT_BIT_WIDTH, default 8: width of the measured result.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 trigger_in  input  1  start/enable of the delay being measured; synchronous to clk.
REQ-006 delay_in_n  input  1  active-low delayed output under measurement; synchronous to clk.
REQ-007 mode_a  input  1  scale select LSB.
REQ-008 mode_b  input  1  scale select MSB.
REQ-009 weighted_bits_out  output  WEIGHT_BIT_WIDTH  last measured, scaled delay.
REQ-010 meas_valid  output  1  one-cycle pulse when weighted_bits_out updates.
REQ-011 overflow  output  1  last result saturated; updates with meas_valid.
REQ-012 abort  output  1  one-cycle pulse when a measurement is cancelled.
REQ-013 busy  output  1  high while in MEASURE.

Function
REQ-014 The block SHALL register trigger_in once (trig_q); rise = trigger_in & ~trig_q.
REQ-015 States SHALL be IDLE, MEASURE, DONE; reset state IDLE.
REQ-016 Edge E0 = first edge where rise is sampled in IDLE; at E0 the block SHALL clear the cycle counter and enter MEASURE; if delay_in_n is also sampled 0 at E0, it SHALL enter DONE with raw count 0.
REQ-017 Raw count SHALL equal k, where E0+k is the first edge in MEASURE at which delay_in_n is sampled 0; that edge SHALL move the state to DONE.
REQ-018 Raw counter width SHALL be WEIGHT_BIT_WIDTH+3, saturating at all-ones; no wrap.
REQ-019 Scale shift S = {mode_b,mode_a} (0..3), sampled at E0 and held for the measurement; result = raw >> S (truncating).
REQ-020 If raw >> S exceeds 2^WEIGHT_BIT_WIDTH-1, the result SHALL be all-ones and overflow SHALL be 1; otherwise overflow SHALL be 0.
REQ-021 In DONE (exactly one cycle) weighted_bits_out and overflow SHALL be loaded and meas_valid SHALL be 1; next state IDLE.
REQ-022 Latency: meas_valid SHALL be high in the cycle immediately after the edge that samples delay_in_n low.
REQ-023 If trigger_in is sampled 0 in MEASURE while delay_in_n is sampled 1, the block SHALL pulse abort for one cycle, return to IDLE, and leave weighted_bits_out and overflow unchanged.
REQ-024 If trigger_in is 0 and delay_in_n is 0 on the same edge in MEASURE, completion SHALL take priority over abort.
REQ-025 trigger_in held high through DONE/IDLE SHALL NOT restart; a new measurement requires a new rise.
REQ-026 A rise during MEASURE or DONE SHALL be ignored.
REQ-027 Mode inputs SHALL be ignored outside E0.

Reset
REQ-028 On rst=1, immediately and regardless of clk: state IDLE, counter 0, trig_q 0, weighted_bits_out 0, meas_valid 0, overflow 0, abort 0, busy 0.
REQ-029 Reset asserted mid-MEASURE SHALL discard the measurement with no meas_valid or abort pulse.
REQ-030 After rst deasserts with trigger_in already high, the first edge SHALL see a rise (trig_q=0) and start a measurement.

Verification
REQ-031 W=8, mode 00, trigger rise at E0, delay_in_n low first sampled at E0+10 -> weighted_bits_out=10, overflow=0, meas_valid high exactly one cycle.
REQ-032 Mode 11, delay_in_n low at E0+83 -> weighted_bits_out=10 (83>>3), overflow=0.
REQ-033 Mode 00, delay_in_n low at E0+300 -> weighted_bits_out=255, overflow=1; mode 10 same delay -> 75, overflow=0.
REQ-034 After a result of 10, trigger dropped at E0+5 with delay_in_n high -> abort one-cycle pulse, no meas_valid, output stays 10, busy low.
REQ-035 delay_in_n already low at E0 -> result 0, meas_valid next cycle; trigger held high afterwards -> no further meas_valid.
REQ-036 rst pulsed at E0+4 of a measurement -> all outputs 0 asynchronously, no pulses; next trigger rise measures normally.
